// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss/fill handshake bundle between the cache pipeline, RAM controller and fill FSM
//
// Signals:
//   miss_detected      pipeline -> fsm  lookup missed this cycle
//   miss_address[15:0] pipeline -> fsm  byte address of the missing access
//   memory_data_valid  ram -> fsm       requested word is returned this cycle
//   cache_miss         fsm -> ram       read request, held until data valid
//   memory_address     fsm -> ram       byte address of the requested word
//   fsm_busy           fsm -> pipeline  stall while a fill is in progress
//   write_data_array   fsm -> cache     write returned word into data array
//   data_word_index    fsm -> cache     word slot within the block
//   write_tag_array    fsm -> cache     write tag/valid for the filled block
//   fill_block_address fsm -> cache     latched block base address
// Modports: master = fill FSM, slave = surrounding cache/RAM logic.
interface cache_fill_fsm_if #(
  parameter int WORD_BITS = 3
);
  logic                 miss_detected;
  logic [15:0]          miss_address;
  logic                 memory_data_valid;
  logic                 cache_miss;
  logic [15:0]          memory_address;
  logic                 fsm_busy;
  logic                 write_data_array;
  logic [WORD_BITS-1:0] data_word_index;
  logic                 write_tag_array;
  logic [15:0]          fill_block_address;

  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output cache_miss, memory_address, fsm_busy, write_data_array,
           data_word_index, write_tag_array, fill_block_address
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  cache_miss, memory_address, fsm_busy, write_data_array,
           data_word_index, write_tag_array, fill_block_address
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill sequencer: fetches a block word by word, then writes its tag
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any fill in progress
//   bus    cache_fill_fsm_if.master (see interface file for signal list)
// Parameter:
//   WORD_BITS  log2 of 16-bit words per block (block = 2^(WORD_BITS+1) bytes)
module cache_fill_fsm #(
  parameter int WORD_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_fill_fsm_if.master        bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_TAG  = 2'd2;

  // Byte-offset bits within a block; cleared when latching the base so the
  // per-word address add can never carry past the block boundary.
  localparam logic [15:0] OFFSET_MASK = 16'((32'd1 << (WORD_BITS + 1)) - 32'd1);
  localparam logic [WORD_BITS-1:0] LAST_WORD = {WORD_BITS{1'b1}};

  logic [1:0]           state;
  logic [WORD_BITS-1:0] counter;
  logic [15:0]          base;

  logic in_fill;
  logic in_tag;
  logic in_idle;
  logic word_done;
  logic [15:0] word_offset;

  assign in_fill   = (state == S_FILL);
  assign in_tag    = (state == S_TAG);
  // Unused encoding 2'd3 falls into idle behaviour.
  assign in_idle   = !(in_fill || in_tag);
  assign word_done = in_fill && bus.memory_data_valid;
  assign word_offset = 16'({counter, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      counter <= '0;
      base    <= 16'h0000;
    end else begin
      case (state)
        S_FILL: begin
          if (bus.memory_data_valid) begin
            if (counter == LAST_WORD) begin
              state <= S_TAG;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        S_TAG: begin
          state <= S_IDLE;
        end
        default: begin
          if (bus.miss_detected) begin
            base    <= bus.miss_address & ~OFFSET_MASK;
            counter <= '0;
            state   <= S_FILL;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cache_miss         = in_fill;
  assign bus.memory_address     = in_fill ? (base + word_offset) : 16'h0000;
  // Stall must rise in the miss cycle itself, before the state register moves.
  assign bus.fsm_busy           = !in_idle || bus.miss_detected;
  assign bus.write_data_array   = word_done;
  assign bus.data_word_index    = word_done ? counter : '0;
  assign bus.write_tag_array    = in_tag;
  assign bus.fill_block_address = in_idle ? 16'h0000 : base;

endmodule
